// File: rtl/traffic_pkg.sv
// Shared intersection package: sensor qualifier state encodings and default timing constants.
package traffic_pkg;

  localparam int unsigned SQ_DEBOUNCE_CYCLES = 4;
  localparam int unsigned SQ_HOLD_CYCLES     = 8;
  localparam int unsigned SQ_CNT_W           = 8;
  localparam int unsigned SQ_STUCK_CYCLES    = 1024;

  typedef enum logic [2:0] {
    SQ_IDLE    = 3'd0,
    SQ_ARM     = 3'd1,
    SQ_PRESENT = 3'd2,
    SQ_HOLD    = 3'd3,
    SQ_FAULT   = 3'd4
  } sq_state_e;

  // States in which the farm road is reported as occupied.
  function automatic logic sq_sensor_on(input sq_state_e s);
    return (s == SQ_PRESENT) || (s == SQ_HOLD) || (s == SQ_FAULT);
  endfunction

endpackage

// File: rtl/sensor_qualifier_if.sv
// Loop-detector qualifier bus: raw detector/clear in, qualified presence and arrival stats out.
interface sensor_qualifier_if #(
  parameter int unsigned CNT_W = 8
) ();

  logic             raw_in;
  logic             clr_count;
  logic             sensor;
  logic             arrival_pulse;
  logic [CNT_W-1:0] vehicle_count;
  logic             sensor_fault;

  modport master (
    output raw_in, clr_count,
    input  sensor, arrival_pulse, vehicle_count, sensor_fault
  );

  modport slave (
    input  raw_in, clr_count,
    output sensor, arrival_pulse, vehicle_count, sensor_fault
  );

endinterface

// File: rtl/sync_2ff.sv
// Two-stage synchroniser for a single asynchronous input, reset to 0.
module sync_2ff (
  input  logic clk,
  input  logic rst_n,
  input  logic i_d,
  output logic o_q
);

  logic r_meta;

  // Two back-to-back flops give metastability settling time.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_meta <= 1'b0;
      o_q    <= 1'b0;
    end else begin
      r_meta <= i_d;
      o_q    <= r_meta;
    end
  end

endmodule

// File: rtl/sensor_qualifier.sv
// Farm-road loop detector qualifier: synchronise, debounce, bridge short gaps, count arrivals.
// Optional stuck-presence detection is built when STUCK_DETECT_EN is defined.
module sensor_qualifier
  import traffic_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = SQ_DEBOUNCE_CYCLES,
  parameter int unsigned HOLD_CYCLES     = SQ_HOLD_CYCLES,
  parameter int unsigned CNT_W           = SQ_CNT_W
`ifdef STUCK_DETECT_EN
  ,
  parameter int unsigned STUCK_CYCLES    = SQ_STUCK_CYCLES
`endif
) (
  input  logic               clk,
  input  logic               rst_n,
  sensor_qualifier_if.slave  bus
);

  localparam int unsigned DEB_W  = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int unsigned HOLD_W = $clog2(HOLD_CYCLES + 1);

  logic              w_s_sync;
  sq_state_e         r_state, w_state_nxt;
  logic [DEB_W-1:0]  r_deb_cnt, w_deb_cnt_nxt;
  logic [HOLD_W-1:0] r_hold_cnt, w_hold_cnt_nxt;
  logic              r_sensor;
  logic              r_arrival;
  logic [CNT_W-1:0]  r_count;

`ifdef STUCK_DETECT_EN
  localparam int unsigned STK_W = $clog2(STUCK_CYCLES + 1);
  logic [STK_W-1:0]  r_stk_cnt, w_stk_cnt_nxt;
  logic              r_fault;
`endif

  sync_2ff u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .i_d   (bus.raw_in),
    .o_q   (w_s_sync)
  );

  // Next-state logic; counters hold the number of qualifying cycles already seen,
  // so the threshold is met on the cycle that completes the run.
  always_comb begin
    w_state_nxt    = r_state;
    w_deb_cnt_nxt  = r_deb_cnt;
    w_hold_cnt_nxt = r_hold_cnt;
`ifdef STUCK_DETECT_EN
    w_stk_cnt_nxt  = '0;
`endif
    case (r_state)
      SQ_IDLE: begin
        if (w_s_sync) begin
          if (DEBOUNCE_CYCLES <= 1) begin
            w_state_nxt = SQ_PRESENT;
          end else begin
            w_state_nxt   = SQ_ARM;
            w_deb_cnt_nxt = DEB_W'(1);
          end
        end
      end
      SQ_ARM: begin
        if (!w_s_sync) begin
          w_state_nxt = SQ_IDLE;
        end else if ((32'(r_deb_cnt) + 32'd1) >= DEBOUNCE_CYCLES) begin
          w_state_nxt = SQ_PRESENT;
        end else begin
          w_deb_cnt_nxt = r_deb_cnt + DEB_W'(1);
        end
      end
      SQ_PRESENT: begin
        if (!w_s_sync) begin
          if (HOLD_CYCLES <= 1) begin
            w_state_nxt = SQ_IDLE;
          end else begin
            w_state_nxt    = SQ_HOLD;
            w_hold_cnt_nxt = HOLD_W'(1);
          end
        end
`ifdef STUCK_DETECT_EN
        else if ((32'(r_stk_cnt) + 32'd1) >= STUCK_CYCLES) begin
          w_state_nxt = SQ_FAULT;
        end else begin
          w_stk_cnt_nxt = r_stk_cnt + STK_W'(1);
        end
`endif
      end
      SQ_HOLD: begin
        if (w_s_sync) begin
          w_state_nxt = SQ_PRESENT;
        end else if ((32'(r_hold_cnt) + 32'd1) >= HOLD_CYCLES) begin
          w_state_nxt = SQ_IDLE;
        end else begin
          w_hold_cnt_nxt = r_hold_cnt + HOLD_W'(1);
        end
      end
`ifdef STUCK_DETECT_EN
      SQ_FAULT: begin
        if (!w_s_sync) begin
          if (HOLD_CYCLES <= 1) begin
            w_state_nxt = SQ_IDLE;
          end else begin
            w_state_nxt    = SQ_HOLD;
            w_hold_cnt_nxt = HOLD_W'(1);
          end
        end
      end
`endif
      default: w_state_nxt = SQ_IDLE;
    endcase
  end

  // State, counters and registered outputs; sensor/arrival track the next state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= SQ_IDLE;
      r_deb_cnt  <= '0;
      r_hold_cnt <= '0;
      r_sensor   <= 1'b0;
      r_arrival  <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_deb_cnt  <= w_deb_cnt_nxt;
      r_hold_cnt <= w_hold_cnt_nxt;
      r_sensor   <= sq_sensor_on(w_state_nxt);
      r_arrival  <= (w_state_nxt == SQ_PRESENT) &&
                    ((r_state == SQ_IDLE) || (r_state == SQ_ARM));
    end
  end

  // Saturating arrival counter; a coincident clear drops that arrival.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count <= '0;
    end else if (bus.clr_count) begin
      r_count <= '0;
    end else if (r_arrival && (r_count != {CNT_W{1'b1}})) begin
      r_count <= r_count + CNT_W'(1);
    end
  end

`ifdef STUCK_DETECT_EN
  // Continuous-presence counter and sticky fault flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_stk_cnt <= '0;
      r_fault   <= 1'b0;
    end else begin
      r_stk_cnt <= w_stk_cnt_nxt;
      r_fault   <= r_fault | (w_state_nxt == SQ_FAULT);
    end
  end

  assign bus.sensor_fault = r_fault;
`else
  assign bus.sensor_fault = 1'b0;
`endif

  assign bus.sensor        = r_sensor;
  assign bus.arrival_pulse = r_arrival;
  assign bus.vehicle_count = r_count;

endmodule
